// File: rtl/io_corner_preio_arbiter_if.sv
// -----------------------------------------------------------------------------
// io_corner_preio_arbiter_if
// Bundles the requester handshake and the pad-side bit signals of the RS_PREIO
// arbiter so they can be passed as one port.
//   req        per-requester level request
//   req_dout   per-requester serial data bit destined for the pad
//   gnt        one-hot-or-zero grant
//   busy       arbiter is not idle
//   done       one-cycle pulse at end of ownership
//   rx_bit     captured pad input bit
//   rx_valid   one-hot qualifier for rx_bit (owner index)
//   pad_outpad towards FPGA_OUT
//   pad_inpad  from FPGA_IN
// Modports: slave = arbiter side, master = requester/pad side.
// -----------------------------------------------------------------------------
interface io_corner_preio_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] req_dout;
   logic [NUM_REQ-1:0] gnt;
   logic               busy;
   logic [NUM_REQ-1:0] done;
   logic               rx_bit;
   logic [NUM_REQ-1:0] rx_valid;
   logic               pad_outpad;
   logic               pad_inpad;

   modport master (
      output req, req_dout, pad_inpad,
      input  gnt, busy, done, rx_bit, rx_valid, pad_outpad
   );

   modport slave (
      input  req, req_dout, pad_inpad,
      output gnt, busy, done, rx_bit, rx_valid, pad_outpad
   );
endinterface

// File: rtl/io_corner_preio_arbiter.sv
// -----------------------------------------------------------------------------
// io_corner_preio_arbiter
// Round-robin arbiter that lets NUM_REQ fabric requesters share one RS_PREIO
// pad path. The owner streams BURST_LEN serial bits to pad_outpad and gets the
// pad_inpad samples back on rx_bit/rx_valid.
// Ports:
//   pad_clk      block clock (same clock as FPGA_CLK)
//   pad_reset_n  asynchronous active-low reset, deassertion synchronised here
//   bus          io_corner_preio_arbiter_if.slave (req/req_dout/gnt/busy/done/
//                rx_bit/rx_valid/pad_outpad/pad_inpad)
// Build option: define PREIO_ARB_SYNC_IN_EN to route pad_inpad through a
// 2-flop synchronizer (rx latency 3 instead of 1).
// Output timing: every output is registered, so the value a state decides on
// is visible in the following cycle (pad shows beat k one cycle after XFER
// beat k, done is high during TURN).
// -----------------------------------------------------------------------------
module io_corner_preio_arbiter #(
   parameter int   NUM_REQ   = 4,
   parameter int   BURST_LEN = 8,
   parameter logic IDLE_VAL  = 1'b0
) (
   input logic                      pad_clk,
   input logic                      pad_reset_n,
   io_corner_preio_arbiter_if.slave bus
);
   localparam int OWN_W = $clog2(NUM_REQ);
   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
`ifdef PREIO_ARB_SYNC_IN_EN
   localparam int TAG_DEPTH = 3;
`else
   localparam int TAG_DEPTH = 1;
`endif

   typedef enum logic [1:0] {IDLE, GRANT, XFER, TURN} state_t;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // (a mod NUM_REQ) for a < 2*NUM_REQ
   function automatic logic [OWN_W-1:0] wrap(input logic [OWN_W:0] s);
      if (s >= (OWN_W+1)'(NUM_REQ))
         wrap = OWN_W'(s - (OWN_W+1)'(NUM_REQ));
      else
         wrap = OWN_W'(s);
   endfunction

   // Reset: asserts asynchronously, releases two pad_clk edges later.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_int_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_int_n  = rst_sync_q[1];

   always_ff @(posedge pad_clk or negedge pad_reset_n) begin
      if (!pad_reset_n) rst_sync_q <= 2'b00;
      else              rst_sync_q <= rst_sync_d;
   end

   state_t             state_q, state_d;
   logic [OWN_W-1:0]   owner_q, owner_d;
   logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               pad_q, pad_d;
   logic               rx_bit_q, rx_bit_d;
   logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
   // Beat tags follow each transferred bit through the pad and input path so
   // rx_valid names the owner of that bit even after ownership has moved on.
   logic [TAG_DEPTH-1:0] tag_v_q, tag_v_d;
   logic [OWN_W-1:0]     tag_own_q [TAG_DEPTH];
   logic [OWN_W-1:0]     tag_own_d [TAG_DEPTH];
   logic                 pad_in_path;
   logic                 xfer_fire;
   logic                 req_own;

   // Requests rotated so position 0 is rr_ptr; lowest set position wins.
   logic [NUM_REQ-1:0] req_rot;
   logic [OWN_W-1:0]   rot_idx [NUM_REQ];
   logic               pick_found;
   logic [OWN_W-1:0]   pick_idx;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot_idx[gi] = wrap({1'b0, rr_ptr_q} + (OWN_W+1)'(gi));
      assign req_rot[gi] = bus.req[rot_idx[gi]];
   end

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            pick_found = 1'b1;
            pick_idx   = rot_idx[i];
         end
      end
   end

`ifdef PREIO_ARB_SYNC_IN_EN
   logic [1:0] sync_q, sync_d;
   assign sync_d      = {sync_q[0], bus.pad_inpad};
   assign pad_in_path = sync_q[1];

   always_ff @(posedge pad_clk or negedge rst_int_n) begin
      if (!rst_int_n) sync_q <= 2'b00;
      else            sync_q <= sync_d;
   end
`else
   assign pad_in_path = bus.pad_inpad;
`endif

   assign req_own = bus.req[owner_q];

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      pad_d     = IDLE_VAL;
      xfer_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = GRANT;
               owner_d = pick_idx;
               gnt_d   = onehot(pick_idx);
            end
         end
         GRANT: begin
            cnt_d = '0;
            if (req_own) begin
               state_d = XFER;
            end else begin
               state_d = TURN;
               gnt_d   = '0;
               done_d  = onehot(owner_q);
            end
         end
         XFER: begin
            if (!req_own) begin
               // voluntary release: this beat is dropped
               state_d = TURN;
               gnt_d   = '0;
               done_d  = onehot(owner_q);
            end else begin
               xfer_fire = 1'b1;
               pad_d     = bus.req_dout[owner_q];
               if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                  state_d = TURN;
                  gnt_d   = '0;
                  done_d  = onehot(owner_q);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         TURN: begin
            state_d  = IDLE;
            cnt_d    = '0;
            rr_ptr_d = wrap({1'b0, owner_q} + (OWN_W+1)'(1));
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tag_v_d      = '0;
      tag_v_d[0]   = xfer_fire;
      tag_own_d[0] = owner_q;
      for (int i = 1; i < TAG_DEPTH; i++) begin
         tag_v_d[i]   = tag_v_q[i-1];
         tag_own_d[i] = tag_own_q[i-1];
      end
      rx_bit_d   = pad_in_path;
      rx_valid_d = tag_v_q[TAG_DEPTH-1] ? onehot(tag_own_q[TAG_DEPTH-1]) : '0;
   end

   always_ff @(posedge pad_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         pad_q      <= IDLE_VAL;
         rx_bit_q   <= 1'b0;
         rx_valid_q <= '0;
         tag_v_q    <= '0;
         tag_own_q  <= '{default: '0};
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         pad_q      <= pad_d;
         rx_bit_q   <= rx_bit_d;
         rx_valid_q <= rx_valid_d;
         tag_v_q    <= tag_v_d;
         tag_own_q  <= tag_own_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.pad_outpad = pad_q;
   assign bus.rx_bit     = rx_bit_q;
   assign bus.rx_valid   = rx_valid_q;
endmodule

// File: tb/tb_io_corner_preio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_corner_preio_arbiter
// Directed bench for io_corner_preio_arbiter (NUM_REQ=4, BURST_LEN=8,
// IDLE_VAL=0) with pad_inpad looped back from pad_outpad.
// -----------------------------------------------------------------------------
module tb_io_corner_preio_arbiter;
   localparam int NUM_REQ = 4;
`ifdef PREIO_ARB_SYNC_IN_EN
   localparam int RX_LAT = 3;
`else
   localparam int RX_LAT = 1;
`endif

   logic pad_clk = 1'b0;
   logic pad_reset_n;
   int   checks_cnt = 0;
   int   errors_cnt = 0;
   logic [7:0] rx_bits;
   int         rx_cnt;
   logic [3:0] rx_own;

   io_corner_preio_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   io_corner_preio_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .BURST_LEN(8),
      .IDLE_VAL (1'b0)
   ) dut (
      .pad_clk    (pad_clk),
      .pad_reset_n(pad_reset_n),
      .bus        (bus.slave)
   );

   assign bus.pad_inpad = bus.pad_outpad;

   always #5 pad_clk = ~pad_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit after the edge, collect rx beats.
   task automatic tick();
      @(posedge pad_clk);
      #1;
      if (bus.rx_valid != 4'b0000) begin
         rx_bits = {rx_bits[6:0], bus.rx_bit};
         rx_cnt++;
         rx_own  = rx_own | bus.rx_valid;
      end
   endtask

   // One ownership from the IDLE cycle before the grant to the IDLE cycle after
   // TURN. nb < 8 drops req[own] during XFER beat nb (early release).
   task automatic burst(input logic [1:0] own, input logic [7:0] pat, input int nb);
      logic [3:0] oh;
      logic [7:0] drv;
      oh  = 4'b0001 << own;
      drv = pat;
      tick();
      chk("grant_gnt",  32'(bus.gnt), 32'(oh));
      chk("grant_busy", 32'(bus.busy), 32'd1);
      chk("grant_pad",  32'(bus.pad_outpad), 32'd0);
      tick();
      chk("xfer0_pad", 32'(bus.pad_outpad), 32'd0);
      chk("xfer0_gnt", 32'(bus.gnt), 32'(oh));
      bus.req_dout      = 4'b0000;
      bus.req_dout[own] = drv[7];
      for (int k = 0; k < nb; k++) begin
         tick();
         chk("beat_pad", 32'(bus.pad_outpad), 32'(drv[7]));
         if (k == 7) begin
            chk("turn_gnt",  32'(bus.gnt), 32'd0);
            chk("turn_done", 32'(bus.done), 32'(oh));
         end else begin
            chk("beat_gnt",  32'(bus.gnt), 32'(oh));
            chk("beat_done", 32'(bus.done), 32'd0);
         end
         drv = drv << 1;
         if (k + 1 < nb) bus.req_dout[own] = drv[7];
         else if (nb < 8) bus.req[own] = 1'b0;
      end
      if (nb < 8) begin
         tick();
         chk("rel_done", 32'(bus.done), 32'(oh));
         chk("rel_gnt",  32'(bus.gnt), 32'd0);
         chk("rel_pad",  32'(bus.pad_outpad), 32'd0);
      end
      tick();
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_pad",  32'(bus.pad_outpad), 32'd0);
      chk("idle_gnt",  32'(bus.gnt), 32'd0);
      bus.req_dout = 4'b0000;
      $display("burst owner=%0d pattern=%08b beats=%0d", own, pat, nb);
   endtask

   task automatic rx_clear();
      rx_bits = 8'h00;
      rx_cnt  = 0;
      rx_own  = 4'b0000;
   endtask

   initial begin
      bus.req      = 4'b0000;
      bus.req_dout = 4'b0000;
      pad_reset_n  = 1'b0;
      rx_clear();

      // Reset state
      repeat (2) tick();
      chk("rst_gnt",   32'(bus.gnt), 32'd0);
      chk("rst_busy",  32'(bus.busy), 32'd0);
      chk("rst_pad",   32'(bus.pad_outpad), 32'd0);
      chk("rst_done",  32'(bus.done), 32'd0);
      chk("rst_rxv",   32'(bus.rx_valid), 32'd0);
      chk("rst_rxbit", 32'(bus.rx_bit), 32'd0);
      $display("reset checked");
      pad_reset_n = 1'b1;
      repeat (2) tick();

      // Round robin with all requests held: owners 0,1,2,3,0
      bus.req = 4'b1111;
      burst(2'd0, 8'b10110010, 8);
      burst(2'd1, 8'b01011100, 8);
      burst(2'd2, 8'b11100001, 8);
      burst(2'd3, 8'b00111010, 8);
      burst(2'd0, 8'b10010110, 8);
      bus.req = 4'b0000;
      repeat (RX_LAT + 1) tick();
      chk("rr_quiet_busy", 32'(bus.busy), 32'd0);

      // Single requester with loopback rx check
      rx_clear();
      bus.req = 4'b0001;
      burst(2'd0, 8'b10110010, 8);
      bus.req = 4'b0000;
      repeat (RX_LAT + 1) tick();
      chk("lb_rx_cnt",  32'(rx_cnt), 32'd8);
      chk("lb_rx_bits", 32'(rx_bits), 32'hB2);
      chk("lb_rx_own",  32'(rx_own), 32'h1);
      $display("loopback rx beats=%0d bits=%08b", rx_cnt, rx_bits);

      // Early release of requester 2 at beat 3
      rx_clear();
      bus.req = 4'b0100;
      burst(2'd2, 8'b11010110, 3);
      repeat (RX_LAT + 1) tick();
      chk("er_rx_cnt",  32'(rx_cnt), 32'd3);
      chk("er_rx_bits", 32'(rx_bits), 32'h06);
      chk("er_rx_own",  32'(rx_own), 32'h4);

      // rr_ptr is now 3: requester 3 beats requester 0; release during GRANT
      bus.req = 4'b1001;
      tick();
      chk("ptr3_gnt", 32'(bus.gnt), 32'h8);
      bus.req = 4'b0000;
      tick();
      chk("grel_done", 32'(bus.done), 32'h8);
      chk("grel_gnt",  32'(bus.gnt), 32'd0);
      tick();
      chk("grel_busy", 32'(bus.busy), 32'd0);
      chk("grel_done_end", 32'(bus.done), 32'd0);
      $display("grant-cycle release owner=3");

      // Reset during XFER beat 5
      bus.req      = 4'b0001;
      bus.req_dout = 4'b0001;
      tick();
      chk("mr_gnt", 32'(bus.gnt), 32'h1);
      repeat (6) tick();
      chk("mr_pad_before", 32'(bus.pad_outpad), 32'd1);
      #2;
      pad_reset_n = 1'b0;
      #1;
      chk("mr_gnt_rst",  32'(bus.gnt), 32'd0);
      chk("mr_pad_rst",  32'(bus.pad_outpad), 32'd0);
      chk("mr_busy_rst", 32'(bus.busy), 32'd0);
      chk("mr_done_rst", 32'(bus.done), 32'd0);
      chk("mr_rxv_rst",  32'(bus.rx_valid), 32'd0);
      bus.req      = 4'b0010;
      bus.req_dout = 4'b0000;
      tick();
      chk("mr_done_hold", 32'(bus.done), 32'd0);
      chk("mr_gnt_hold",  32'(bus.gnt), 32'd0);
      pad_reset_n = 1'b1;
      tick();
      chk("rel_edge1_gnt", 32'(bus.gnt), 32'd0);
      tick();
      chk("rel_edge2_gnt", 32'(bus.gnt), 32'd0);
      chk("rel_edge2_done", 32'(bus.done), 32'd0);
      tick();
      chk("rel_edge3_gnt", 32'(bus.gnt), 32'h2);
      $display("reset mid-burst, first grant owner=1");
      bus.req = 4'b0000;
      repeat (3) tick();
      chk("final_busy", 32'(bus.busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end
endmodule

// File: doc/io_corner_preio_arbiter.md
IO_CORNER_PREIO_ARBITER -- requirements
Module: io_corner_preio_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of fabric requesters sharing one RS_PREIO pad path; legal range 2..8.
REQ-002 Parameter BURST_LEN, default 8: XFER cycles per grant; legal range 1..256.
REQ-003 Parameter IDLE_VAL, default 1'b0: value driven on pad_outpad when no requester owns the pad.
REQ-004 One clock and one reset; reset is asynchronous, active-low. Ports:
REQ-005 pad_clk  input  1  block clock; the same clock that drives the pad primitive FPGA_CLK.
REQ-006 pad_reset_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_REQ  per-requester level request; held until done or voluntary release.
REQ-008 req_dout  input  NUM_REQ  per-requester serial data bit destined for the pad.
REQ-009 gnt  output  NUM_REQ  one-hot-or-zero grant.
REQ-010 busy  output  1  high in every state other than IDLE.
REQ-011 pad_outpad  output  1  to the pad primitive FPGA_OUT.
REQ-012 pad_inpad  input  1  from the pad primitive FPGA_IN.
REQ-013 rx_bit  output  1  captured pad_inpad bit.
REQ-014 rx_valid  output  NUM_REQ  one-hot qualifier for rx_bit, owner index only.
REQ-015 done  output  NUM_REQ  one-cycle pulse at end of ownership.

Function
REQ-016 FSM states IDLE, GRANT, XFER, TURN; exactly one active per cycle.
REQ-017 IDLE: if any req bit is high, the owner is the first set index at or after rr_ptr (wrapping); next state GRANT; gnt[owner] registered high on entry to GRANT.
REQ-018 GRANT: one cycle; pad_outpad = IDLE_VAL; next XFER, or TURN if req[owner] is low.
REQ-019 XFER: beat counter (width clog2(BURST_LEN), min 1) starts at 0 and increments each cycle; pad_outpad registered, pad_outpad(t+1) = req_dout[owner](t).
REQ-020 XFER: pad_inpad sampled every cycle; rx_bit/rx_valid[owner] asserted the following cycle (1-cycle latency; 3 with macro, REQ-031).
REQ-021 XFER exit: after the beat with counter == BURST_LEN-1, or immediately when req[owner] is low (that beat is not transferred), go to TURN.
REQ-022 TURN: one cycle; gnt = 0; done[owner] pulses; pad_outpad = IDLE_VAL; rr_ptr = (owner+1) mod NUM_REQ; next IDLE.
REQ-023 A requester cannot re-win before the others: owner's req held high through TURN gets priority only after every pending lower-rank index in the rotation.
REQ-024 req changes on non-owner bits during GRANT/XFER/TURN are ignored until IDLE.
REQ-025 gnt, rx_valid and done are never multi-hot; rx_valid never asserts outside the pipeline tail of XFER.

Reset
REQ-026 On pad_reset_n low, asynchronously: state IDLE, gnt = 0, busy = 0, pad_outpad = IDLE_VAL, rx_bit = 0, rx_valid = 0, done = 0, rr_ptr = 0, counter = 0, synchronizer flops = 0.
REQ-027 Reset mid-burst aborts without a done pulse; outputs reach reset values within the same cycle.
REQ-028 Reset deassertion is synchronised internally to pad_clk (2-flop); first grant no earlier than the third pad_clk edge after release.

Configuration
REQ-029 Macro PREIO_ARB_SYNC_IN_EN selects the pad_inpad input path.
REQ-030 Without the macro: pad_inpad is sampled directly; rx latency is 1 cycle.
REQ-031 With the macro: pad_inpad passes a 2-flop synchronizer before capture; rx latency is 3 cycles; rx_valid tracks the delayed beats, including the final beats after the state has reached TURN/IDLE; owner tag delayed accordingly.

Verification
REQ-032 Single requester: req=4'b0001, req_dout pattern 10110010, BURST_LEN=8 -> gnt=0001 next cycle, pad_outpad shows 10110010 over 8 cycles, done[0] single pulse, busy low 1 cycle after TURN.
REQ-033 Round robin: req=4'b1111 held -> owners 0,1,2,3,0 in order, exactly 8 XFER beats each, one TURN cycle between grants with pad_outpad=IDLE_VAL.
REQ-034 Early release: req[2] dropped at XFER beat 3 -> TURN next cycle, done[2] pulses, only 3 beats seen on pad_outpad, rr_ptr=3.
REQ-035 Loopback pad_inpad=pad_outpad: rx_bit reproduces req_dout with rx_valid[owner] at latency 1 (3 with PREIO_ARB_SYNC_IN_EN), 8 valid beats.
REQ-036 Reset at XFER beat 5 -> gnt=0, pad_outpad=IDLE_VAL immediately, no done pulse; after release with req=0010, requester 1 granted first (rr_ptr=0 and requester 1 is the first pending index).
